ray_hit_resolver: RTL and testbench
===================================

RAY_HIT_RESOLVER -- requirements
Module: ray_hit_resolver

Interface
REQ-001 SHALL have parameter TRACE_LAT, default 4, cycles from object_out stable to valid t_in from the sphere tracer.
REQ-002 SHALL have parameter MAX_OBJ, default 16, maximum objects per ray (address width 4).
REQ-003 SHALL have parameter T_MISS, default 10'h3FF, t value meaning "no intersection".
REQ-004 SHALL have parameter BG_COLOR, default 12'h000, colour reported on total miss.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  one-cycle pulse, begin resolving the current ray.
REQ-009 num_obj  input  5  object count for this ray, 0..MAX_OBJ, sampled on accepted start.
REQ-010 obj_addr  output  4  object-list read address.
REQ-011 obj_data  input  48  object word {colour[11:0], radius[7:0], x[9:0], y[9:0], z[7:0]}, valid one cycle after obj_addr.
REQ-012 object_out  output  48  object word driven to the sphere tracer.
REQ-013 t_in  input  10  sphere tracer intersection distance.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle pulse, results valid.
REQ-016 hit  output  1  any object intersected.
REQ-017 t_min  output  10  nearest distance (T_MISS when no hit).
REQ-018 color  output  12  colour of nearest object (BG_COLOR when no hit).
REQ-019 hit_idx  output  4  index of nearest object (0 when no hit).

Function
REQ-020 SHALL implement FSM IDLE -> FETCH -> TRACE -> COMPARE -> (FETCH | DONE) -> IDLE.
REQ-021 IDLE: start accepted only here; latch num_obj, idx=0, best_t=T_MISS, best_color=BG_COLOR, best_idx=0, found=0; go FETCH, or DONE directly if num_obj==0.
REQ-022 FETCH: drive obj_addr=idx for one cycle; next cycle register obj_data into object_out and go TRACE.
REQ-023 TRACE: hold object_out constant for exactly TRACE_LAT cycles, then sample t_in and go COMPARE.
REQ-024 COMPARE: if t_in != T_MISS and t_in < best_t (strict, unsigned), update best_t, best_color=object_out[47:36], best_idx=idx, found=1; ties keep lower index.
REQ-025 COMPARE: if idx == num_obj-1 go DONE, else idx+1 and go FETCH.
REQ-026 DONE: register hit/t_min/color/hit_idx from best_*, pulse done for one cycle, go IDLE; outputs hold until next done.
REQ-027 Per-object cost SHALL be TRACE_LAT+3 cycles; start-to-done latency num_obj*(TRACE_LAT+3)+2 cycles (2 when num_obj==0).
REQ-028 start while busy SHALL be ignored; start in the cycle done pulses SHALL be ignored.
REQ-029 num_obj > MAX_OBJ SHALL be clamped to MAX_OBJ.
REQ-030 busy SHALL deassert in the same cycle done asserts.

Reset
REQ-031 rst SHALL force IDLE, busy=0, done=0, hit=0, t_min=T_MISS, color=BG_COLOR, hit_idx=0, obj_addr=0, object_out=0.
REQ-032 rst mid-operation SHALL abort with no done pulse; rst dominates a simultaneous start.

Structure
REQ-033 Object-word field offsets, T_MISS, BG_COLOR and FSM state encoding SHALL live in shared package ray_pkg.
REQ-034 SHALL instantiate no sub-modules; the sphere tracer and object list sit outside and connect via object_out/t_in and obj_addr/obj_data.

Verification
REQ-035 num_obj=0, start -> done after 2 cycles, hit=0, t_min=3FF, color=000.
REQ-036 3 objects, t_in model returns 40, 25, 60 -> hit=1, t_min=25, hit_idx=1, colour of object 1, done at cycle 3*(TRACE_LAT+3)+2.
REQ-037 2 objects both t=3FF -> hit=0, t_min=3FF, color=BG_COLOR.
REQ-038 2 objects both t=30, colours FFF and 0F0 -> hit_idx=0, color=FFF.
REQ-039 start re-pulsed while busy -> ignored, single done; rst asserted during TRACE of object 1 -> no done, outputs at reset values, next start runs cleanly.
REQ-040 num_obj=20 with MAX_OBJ=16 -> exactly 16 reads (obj_addr 0..15), done after 16*(TRACE_LAT+3)+2 cycles.

Source files
------------

// File: rtl/ray_pkg.sv
// ray_pkg: shared object-word layout, miss/background constants and FSM encoding for the hit resolver.
package ray_pkg;
    localparam int OBJ_W      = 48;
    localparam int COLOR_LSB  = 36;
    localparam int COLOR_W    = 12;
    localparam int RADIUS_LSB = 28;
    localparam int RADIUS_W   = 8;
    localparam int X_LSB      = 18;
    localparam int X_W        = 10;
    localparam int Y_LSB      = 8;
    localparam int Y_W        = 10;
    localparam int Z_LSB      = 0;
    localparam int Z_W        = 8;
    localparam logic [9:0]  T_MISS_DEF   = 10'h3FF;
    localparam logic [11:0] BG_COLOR_DEF = 12'h000;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_TRACE,
        S_COMPARE,
        S_DONE
    } state_t;
endpackage

// File: rtl/ray_hit_resolver.sv
// ray_hit_resolver: walks a ray's object list through an external sphere tracer and keeps the nearest hit.
module ray_hit_resolver
    import ray_pkg::*;
#(
    parameter int          TRACE_LAT = 4,
    parameter int          MAX_OBJ   = 16,
    parameter logic [9:0]  T_MISS    = T_MISS_DEF,
    parameter logic [11:0] BG_COLOR  = BG_COLOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  num_obj,
    output logic [3:0]  obj_addr,
    input  logic [47:0] obj_data,
    output logic [47:0] object_out,
    input  logic [9:0]  t_in,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic [9:0]  t_min,
    output logic [11:0] color,
    output logic [3:0]  hit_idx
);
    state_t      state_q, state_d;
    logic [4:0]  num_q, num_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  best_t_q, best_t_d;
    logic [11:0] best_color_q, best_color_d;
    logic [3:0]  best_idx_q, best_idx_d;
    logic        found_q, found_d;
    logic [47:0] obj_q, obj_d;
    logic        done_q, done_d;
    logic        hit_q, hit_d;
    logic [9:0]  t_min_q, t_min_d;
    logic [11:0] color_q, color_d;
    logic [3:0]  hit_idx_q, hit_idx_d;
    logic [4:0]  num_clamped;
    logic        better, last;

    assign num_clamped = num_obj > 5'(MAX_OBJ) ? 5'(MAX_OBJ) : num_obj;
    assign better      = t_in != T_MISS && t_in < best_t_q;
    assign last        = {1'b0, idx_q} == num_q - 5'd1;

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        best_t_d     = best_t_q;
        best_color_d = best_color_q;
        best_idx_d   = best_idx_q;
        found_d      = found_q;
        obj_d        = obj_q;
        done_d       = 1'b0;
        hit_d        = hit_q;
        t_min_d      = t_min_q;
        color_d      = color_q;
        hit_idx_d    = hit_idx_q;
        case (state_q)
            S_IDLE: begin
                // the cycle done pulses is still IDLE, so a start there must be refused explicitly
                if (start && !done_q) begin
                    num_d        = num_clamped;
                    idx_d        = 4'd0;
                    cnt_d        = 8'd0;
                    best_t_d     = T_MISS;
                    best_color_d = BG_COLOR;
                    best_idx_d   = 4'd0;
                    found_d      = 1'b0;
                    state_d      = num_clamped == 5'd0 ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd1) begin
                    obj_d   = obj_data;
                    cnt_d   = 8'd0;
                    state_d = S_TRACE;
                end
            end
            S_TRACE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(TRACE_LAT - 1)) begin
                    cnt_d   = 8'd0;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (better) begin
                    best_t_d     = t_in;
                    best_color_d = obj_q[COLOR_LSB +: COLOR_W];
                    best_idx_d   = idx_q;
                    found_d      = 1'b1;
                end
                idx_d   = last ? idx_q : idx_q + 4'd1;
                state_d = last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                hit_d     = found_q;
                t_min_d   = best_t_q;
                color_d   = best_color_q;
                hit_idx_d = best_idx_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            num_q        <= 5'd0;
            idx_q        <= 4'd0;
            cnt_q        <= 8'd0;
            best_t_q     <= T_MISS;
            best_color_q <= BG_COLOR;
            best_idx_q   <= 4'd0;
            found_q      <= 1'b0;
            obj_q        <= '0;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            t_min_q      <= T_MISS;
            color_q      <= BG_COLOR;
            hit_idx_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            best_t_q     <= best_t_d;
            best_color_q <= best_color_d;
            best_idx_q   <= best_idx_d;
            found_q      <= found_d;
            obj_q        <= obj_d;
            done_q       <= done_d;
            hit_q        <= hit_d;
            t_min_q      <= t_min_d;
            color_q      <= color_d;
            hit_idx_q    <= hit_idx_d;
        end
    end

    assign obj_addr   = idx_q;
    assign object_out = obj_q;
    assign busy       = state_q != S_IDLE;
    assign done       = done_q;
    assign hit        = hit_q;
    assign t_min      = t_min_q;
    assign color      = color_q;
    assign hit_idx    = hit_idx_q;
endmodule

// File: tb/tb_ray_hit_resolver.sv
// tb_ray_hit_resolver: random and directed rays checked against a nearest-hit reference model.
module tb_ray_hit_resolver;
    localparam int L = 4;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [4:0]  num_obj;
    logic [3:0]  obj_addr;
    logic [47:0] obj_data, object_out;
    logic [9:0]  t_in;
    logic        busy, done, hit;
    logic [9:0]  t_min;
    logic [11:0] color;
    logic [3:0]  hit_idx;
    logic [9:0]  mt [16];
    logic [11:0] mc [16];
    logic [9:0]  trc [L];
    int          total = 0;
    int          bad = 0;

    ray_hit_resolver dut (
        .clk(clk), .rst(rst), .start(start), .num_obj(num_obj),
        .obj_addr(obj_addr), .obj_data(obj_data), .object_out(object_out),
        .t_in(t_in), .busy(busy), .done(done), .hit(hit),
        .t_min(t_min), .color(color), .hit_idx(hit_idx)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) obj_data <= {mc[obj_addr], 8'h11, mt[obj_addr], 10'h0AB, 8'h5C};

    // tracer stand-in: reports the x field as the distance, TRACE_LAT cycles after object_out settles
    always_ff @(posedge clk) begin
        trc[0] <= object_out[27:18];
        for (int i = 1; i < L; i++) trc[i] <= trc[i-1];
    end
    assign t_in = trc[L-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_hit"}, hit, 0);
        chk({tag, "_tmin"}, t_min, 10'h3FF);
        chk({tag, "_color"}, color, 12'h000);
        chk({tag, "_idx"}, hit_idx, 0);
        chk({tag, "_addr"}, obj_addr, 0);
        chk({tag, "_obj"}, object_out, 0);
    endtask

    task automatic run(input int n, input bit repulse, input bit start_at_done);
        int          ne, lat, k, nseen;
        bit          ehit;
        logic [9:0]  et;
        logic [11:0] ec;
        logic [3:0]  ei;
        bit          seen [16];
        ne = n > 16 ? 16 : n;
        lat = ne * (L + 3) + 2;
        ehit = 0; et = 10'h3FF; ec = 12'h000; ei = 0;
        for (int i = 0; i < ne; i++)
            if (mt[i] != 10'h3FF && mt[i] < et) begin
                ehit = 1; et = mt[i]; ec = mc[i]; ei = 4'(i);
            end
        foreach (seen[i]) seen[i] = 0;
        @(posedge clk); #1;
        start = 1; num_obj = 5'(n);
        @(posedge clk); #1;
        start = 0; k = 1;
        chk("busy_after_start", busy, 1);
        while (!done && k < 3000) begin
            if (busy) seen[obj_addr] = 1;
            start = repulse && k == 3;
            num_obj = 5'd1;
            @(posedge clk); #1;
            k++;
        end
        start = 0;
        chk("latency", k, lat);
        chk("busy_at_done", busy, 0);
        chk("hit", hit, ehit);
        chk("t_min", t_min, et);
        chk("color", color, ec);
        chk("hit_idx", hit_idx, ei);
        if (ne > 0) begin
            nseen = 0;
            foreach (seen[i]) nseen += seen[i];
            chk("reads", nseen, ne);
        end
        start = start_at_done; num_obj = 5'd3;
        @(posedge clk); #1;
        start = 0;
        chk("done_single", done, 0);
        chk("idle_after_done", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_t_min", t_min, et);
        chk("hold_color", color, ec);
    endtask

    initial begin
        int dcount;
        rst = 1; start = 0; num_obj = 0;
        for (int i = 0; i < 16; i++) begin mt[i] = 10'h3FF; mc[i] = 12'h000; end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 0;
        run(0, 0, 0);
        mt[0] = 10'd40; mt[1] = 10'd25; mt[2] = 10'd60;
        mc[0] = 12'hA11; mc[1] = 12'hB22; mc[2] = 12'hC33;
        run(3, 1, 1);
        mt[0] = 10'h3FF; mt[1] = 10'h3FF; mc[0] = 12'h123; mc[1] = 12'h456;
        run(2, 0, 0);
        mt[0] = 10'd30; mt[1] = 10'd30; mc[0] = 12'hFFF; mc[1] = 12'h0F0;
        run(2, 0, 0);
        for (int i = 0; i < 16; i++) begin mt[i] = 10'(100 + $urandom_range(0, 50)); mc[i] = 12'($urandom); end
        mt[15] = 10'd7; mc[15] = 12'h9E1;
        run(20, 0, 0);
        mt[0] = 10'd40; mt[1] = 10'd25; mt[2] = 10'd60;
        @(posedge clk); #1;
        start = 1; num_obj = 5'd3;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 200 && obj_addr != 4'd1; i++) begin @(posedge clk); #1; end
        chk("reach_obj1", obj_addr, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1; start = 1;
        @(posedge clk); #1;
        rst = 0; start = 0;
        dcount = 0;
        for (int i = 0; i < 60; i++) begin
            dcount += int'(done);
            @(posedge clk); #1;
        end
        chk("abort_no_done", dcount, 0);
        check_reset_outputs("abort");
        run(3, 0, 0);
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(0, 20);
            for (int i = 0; i < 16; i++) begin
                mt[i] = $urandom_range(0, 3) == 0 ? 10'h3FF : 10'($urandom_range(0, 63));
                mc[i] = 12'($urandom);
            end
            run(n, n > 0 && $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
